video_capture_ctrl: RTL and testbench
=====================================

# video_capture_ctrl

Synthesizable controller that sequences frame capture on the video output path. It tracks frame boundaries from `vid_vsync` and skips a programmable number of frames. It then asserts a capture enable for a programmable number of whole frames. Each captured frame's geometry is checked against WIDTH×HEIGHT. It sits between the video timing generator and any frame consumer (frame writer, frame buffer DMA), gating it so only complete frames are delivered.

## Interface
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, active lines per frame
- `FCW`, 8, width of frame skip/count/index fields
- `vid_clk`  in  1  video clock
- `vid_rst`  in  1  reset, asynchronous, active-high
- `vid_clk_en`  in  1  pixel clock enable; all state advances only when high
- `vid_vsync`  in  1  vertical sync, active-high; rising edge = frame boundary
- `vid_active`  in  1  active-video pixel qualifier
- `cfg_skip`  in  FCW  frames to discard after arming; sampled on `cmd_start`
- `cfg_count`  in  FCW  frames to capture, 0 = continuous; sampled on `cmd_start`
- `cmd_start`  in  1  single-cycle arm request
- `cmd_stop`  in  1  single-cycle stop request
- `cap_en`  out  1  capture enable to consumer
- `cap_sof`  out  1  one-cycle pulse, captured frame begins
- `cap_eof`  out  1  one-cycle pulse, captured frame ended
- `cap_frame_idx`  out  FCW  0-based index of frame in capture
- `busy`  out  1  state ≠ IDLE and ≠ DONE
- `done`  out  1  state == DONE
- `err_geom`  out  1  sticky, a captured frame had wrong pixel/line count

## Operation
- Edge detect: `vs_d` is registered on enabled cycles. `vs_edge = vid_clk_en & vid_vsync & ~vs_d`. `act_d` is handled the same way for `vid_active` falling edges (line end).
- States: IDLE, ARM, SKIP, CAPTURE, DONE.
- IDLE/DONE + `cmd_start`: latch cfg, clear `cap_frame_idx`, `err_geom`, stop_pending → ARM.
- ARM + `vs_edge`: `cfg_skip`==0 → CAPTURE (pulse `cap_sof`). Otherwise load skip_cnt=`cfg_skip` → SKIP.
- SKIP + `vs_edge`: decrement skip_cnt. When skip_cnt==1 → CAPTURE (pulse `cap_sof`). Exactly `cfg_skip` full frames are discarded.
- CAPTURE: count `pix_cnt` on enabled cycles with `vid_active`. Count `line_cnt` on active falling edges. On `vs_edge`:
  - pulse `cap_eof`.
  - set `err_geom` if `pix_cnt`≠WIDTH*HEIGHT or `line_cnt`≠HEIGHT.
  - clear counters.
  - if stop_pending, or (`cfg_count`≠0 and `cap_frame_idx`+1==`cfg_count`), → DONE and hold `cap_frame_idx`.
  - otherwise increment `cap_frame_idx` (wraps modulo 2^FCW in continuous mode), pulse `cap_sof`, stay in CAPTURE.
- `cmd_stop`: in ARM/SKIP → IDLE immediately. In CAPTURE → set stop_pending; the current frame completes, then DONE. Ignored in IDLE/DONE.
- `cmd_start` while busy is ignored. `cmd_start` and `cmd_stop` in the same cycle: stop wins, start ignored.
- Counters saturate at all-ones, sized `$clog2(WIDTH*HEIGHT+1)+1` and `$clog2(HEIGHT+1)+1`. An overflowing frame still flags `err_geom`.
- Commands are accepted on any `vid_clk` cycle regardless of `vid_clk_en`. Frame and pixel events require `vid_clk_en`.

## Timing
- All outputs are registered. Reset values: `cap_en`=0, `cap_sof`=0, `cap_eof`=0, `cap_frame_idx`=0, `busy`=0, `done`=0, `err_geom`=0. State = IDLE, all counters 0, `vs_d`=`act_d`=0.
- `cap_en` rises the cycle after the `vs_edge` that enters CAPTURE. It falls the cycle after the `vs_edge` that leaves CAPTURE. It never toggles mid-frame.
- `cap_sof`/`cap_eof` are high for exactly one `vid_clk` cycle, the cycle after `vs_edge`. Both are high together at back-to-back frame boundaries.
- `busy` rises the cycle after an accepted `cmd_start`.
- `done` stays high until the next accepted `cmd_start`.
- `vid_rst` asserted mid-capture: `cap_en` drops asynchronously and the partial frame is discarded without an `cap_eof`.

## Test plan
- WIDTH=4, HEIGHT=3, `cfg_skip`=2, `cfg_count`=3, correct frames. Expect 2 frames skipped, 3 `cap_sof`/`cap_eof` pairs, `cap_frame_idx` 0→1→2, then `done`=1, `cap_en`=0, `err_geom`=0.
- `cfg_skip`=0, `cfg_count`=0 (continuous), 300 frames. Expect `cap_en` continuously high after the first vsync, and `cap_frame_idx` wrapping 255→0.
- Inject a frame with 11 pixels (one short line). Expect `err_geom`=1 at that `cap_eof`, still set after the following good frames, cleared on the next `cmd_start`.
- `cmd_stop` mid-frame in CAPTURE. Expect `cap_en` held until the next vsync edge, then one `cap_eof` and `done`=1. `cmd_stop` in SKIP: expect IDLE, `busy`=0 the next cycle, and no `cap_sof`.
- `cmd_start` and `cmd_stop` in the same cycle from IDLE: expect the state to remain IDLE. `vid_rst` pulsed mid-capture: expect all outputs at reset values and no `cap_eof`.
- `vid_clk_en` at 1-in-3 duty: expect the same frame/pixel counts as in the first scenario, with `cap_sof`/`cap_eof` still one `vid_clk` wide.

Source files
------------

// File: rtl/video_capture_ctrl_if.sv
// Capture-control bundle: video timing qualifiers, arm/stop commands and capture status.
// The master side drives video and commands; the controller sits on the slave side.
interface video_capture_ctrl_if #(
    parameter int unsigned FCW = 8
);
    logic           vid_clk_en;
    logic           vid_vsync;
    logic           vid_active;
    logic [FCW-1:0] cfg_skip;
    logic [FCW-1:0] cfg_count;
    logic           cmd_start;
    logic           cmd_stop;
    logic           cap_en;
    logic           cap_sof;
    logic           cap_eof;
    logic [FCW-1:0] cap_frame_idx;
    logic           busy;
    logic           done;
    logic           err_geom;

    modport master (
        output vid_clk_en, vid_vsync, vid_active, cfg_skip, cfg_count, cmd_start, cmd_stop,
        input  cap_en, cap_sof, cap_eof, cap_frame_idx, busy, done, err_geom
    );

    modport slave (
        input  vid_clk_en, vid_vsync, vid_active, cfg_skip, cfg_count, cmd_start, cmd_stop,
        output cap_en, cap_sof, cap_eof, cap_frame_idx, busy, done, err_geom
    );
endinterface

// File: rtl/video_capture_ctrl.sv
// Frame capture sequencer: skips N frames after arming, gates M whole frames to the
// consumer and flags any captured frame whose pixel/line geometry is wrong.
module video_capture_ctrl #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned FCW    = 8
) (
    input  logic                vid_clk,
    input  logic                vid_rst,
    video_capture_ctrl_if.slave bus
);
    localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
    localparam int unsigned PIX_W     = $clog2(FRAME_PIX + 1) + 1;
    localparam int unsigned LINE_W    = $clog2(HEIGHT + 1) + 1;

    typedef enum logic [2:0] {IDLE, ARM, SKIP, CAPTURE, DONE} state_t;

    state_t            state, state_nxt;
    logic              vs_d, act_d;
    logic [FCW-1:0]    skip_cnt, skip_cnt_nxt;
    logic [FCW-1:0]    count_q, count_nxt;
    logic [FCW-1:0]    idx, idx_nxt;
    logic              stop_pend, stop_pend_nxt;
    logic [PIX_W-1:0]  pix_cnt, pix_cnt_nxt;
    logic [LINE_W-1:0] line_cnt, line_cnt_nxt;
    logic              err, err_nxt;
    logic              sof_nxt, eof_nxt;
    logic              en_q, sof_q, eof_q, busy_q, done_q;

    logic vs_edge, line_end, start_ok, stop_req, last_frame, geom_bad;

    assign vs_edge    = bus.vid_clk_en & bus.vid_vsync & ~vs_d;
    assign line_end   = bus.vid_clk_en & ~bus.vid_active & act_d;
    assign start_ok   = bus.cmd_start & ~bus.cmd_stop & ((state == IDLE) || (state == DONE));
    assign stop_req   = stop_pend | bus.cmd_stop;
    // A stop arriving on the closing edge still ends the frame that is completing.
    assign last_frame = stop_req || ((count_q != '0) && (FCW'(idx + 1'b1) == count_q));
    assign geom_bad   = (pix_cnt != PIX_W'(FRAME_PIX)) || (line_cnt != LINE_W'(HEIGHT));

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        skip_cnt_nxt  = skip_cnt;
        count_nxt     = count_q;
        idx_nxt       = idx;
        stop_pend_nxt = stop_pend;
        pix_cnt_nxt   = pix_cnt;
        line_cnt_nxt  = line_cnt;
        err_nxt       = err;
        sof_nxt       = 1'b0;
        eof_nxt       = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt     = ARM;
                    skip_cnt_nxt  = bus.cfg_skip;
                    count_nxt     = bus.cfg_count;
                    idx_nxt       = '0;
                    err_nxt       = 1'b0;
                    stop_pend_nxt = 1'b0;
                end
            end
            ARM: begin
                if (bus.cmd_stop) begin
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    if (skip_cnt == '0) begin
                        state_nxt = CAPTURE;
                        sof_nxt   = 1'b1;
                    end else begin
                        state_nxt = SKIP;
                    end
                end
            end
            SKIP: begin
                if (bus.cmd_stop) begin
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    if (skip_cnt == FCW'(1)) begin
                        state_nxt    = CAPTURE;
                        sof_nxt      = 1'b1;
                        skip_cnt_nxt = '0;
                    end else begin
                        skip_cnt_nxt = FCW'(skip_cnt - 1'b1);
                    end
                end
            end
            CAPTURE: begin
                if (bus.cmd_stop) stop_pend_nxt = 1'b1;
                if (vs_edge) begin
                    eof_nxt      = 1'b1;
                    pix_cnt_nxt  = '0;
                    line_cnt_nxt = '0;
                    if (geom_bad) err_nxt = 1'b1;
                    if (last_frame) begin
                        state_nxt     = DONE;
                        stop_pend_nxt = 1'b0;
                    end else begin
                        idx_nxt = FCW'(idx + 1'b1);
                        sof_nxt = 1'b1;
                    end
                end else begin
                    if (bus.vid_clk_en && bus.vid_active && (pix_cnt != '1))
                        pix_cnt_nxt = PIX_W'(pix_cnt + 1'b1);
                    if (line_end && (line_cnt != '1))
                        line_cnt_nxt = LINE_W'(line_cnt + 1'b1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge vid_clk or posedge vid_rst) begin
        if (vid_rst) begin
            state     <= IDLE;
            vs_d      <= 1'b0;
            act_d     <= 1'b0;
            skip_cnt  <= '0;
            count_q   <= '0;
            idx       <= '0;
            stop_pend <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            err       <= 1'b0;
            en_q      <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (bus.vid_clk_en) begin
                vs_d  <= bus.vid_vsync;
                act_d <= bus.vid_active;
            end
            skip_cnt  <= skip_cnt_nxt;
            count_q   <= count_nxt;
            idx       <= idx_nxt;
            stop_pend <= stop_pend_nxt;
            pix_cnt   <= pix_cnt_nxt;
            line_cnt  <= line_cnt_nxt;
            err       <= err_nxt;
            en_q      <= (state_nxt == CAPTURE);
            sof_q     <= sof_nxt;
            eof_q     <= eof_nxt;
            busy_q    <= state_nxt inside {ARM, SKIP, CAPTURE};
            done_q    <= (state_nxt == DONE);
        end
    end

    assign bus.cap_en        = en_q;
    assign bus.cap_sof       = sof_q;
    assign bus.cap_eof       = eof_q;
    assign bus.cap_frame_idx = idx;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err_geom      = err;
endmodule

// File: tb/tb_video_capture_ctrl.sv
// Bench for video_capture_ctrl: random-geometry frames checked against a frame-level
// model; boundary events go through a queue, level outputs are compared every cycle.
module tb_video_capture_ctrl;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 3;
    localparam int unsigned FCW = 8;

    logic vid_clk = 1'b0;
    logic vid_rst = 1'b0;
    always #5 vid_clk = ~vid_clk;

    video_capture_ctrl_if #(.FCW(FCW)) bus ();

    video_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .FCW(FCW)) dut (
        .vid_clk (vid_clk),
        .vid_rst (vid_rst),
        .bus     (bus)
    );

    typedef struct {
        bit sof;
        bit eof;
        int idx;
        bit err;
    } ev_t;

    ev_t exp_q[$];

    // Frame-level reference model
    bit m_on, m_stop_req, m_err, m_last_bad;
    int m_edge, m_skip, m_count;
    // Expected level outputs
    bit x_en, x_busy, x_done, x_err;
    int x_idx;

    int dead = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit final_req = 1'b0;
    bit final_ack = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: levels every cycle, boundary pulses against the scoreboard
    always @(negedge vid_clk) begin
        ev_t e;
        chk("cap_en", int'(bus.cap_en), int'(x_en));
        chk("busy", int'(bus.busy), int'(x_busy));
        chk("done", int'(bus.done), int'(x_done));
        chk("err_geom", int'(bus.err_geom), int'(x_err));
        chk("cap_frame_idx", int'(bus.cap_frame_idx), x_idx);
        if (bus.cap_sof || bus.cap_eof) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got sof=%0d eof=%0d, expected none at %0t",
                         bus.cap_sof, bus.cap_eof, $time);
            end else begin
                e = exp_q.pop_front();
                chk("ev_sof", int'(bus.cap_sof), int'(e.sof));
                chk("ev_eof", int'(bus.cap_eof), int'(e.eof));
                chk("ev_idx", int'(bus.cap_frame_idx), e.idx);
                chk("ev_err", int'(bus.err_geom), int'(e.err));
            end
        end
        if (final_req && !final_ack) begin
            chk("pending_events", exp_q.size(), 0);
            final_ack = 1'b1;
        end
    end

    function automatic void push_ev(bit sof, bit eof, int idx, bit err);
        ev_t e;
        e.sof = sof;
        e.eof = eof;
        e.idx = idx;
        e.err = err;
        exp_q.push_back(e);
    endfunction

    task automatic drive_tick(bit en, bit vs, bit act);
        bus.vid_clk_en = en;
        bus.vid_vsync  = vs;
        bus.vid_active = act;
        @(posedge vid_clk);
        #1;
    endtask

    task automatic ptick(bit vs, bit act);
        for (int i = 0; i < dead; i++) drive_tick(1'b0, vs, act);
        drive_tick(1'b1, vs, act);
    endtask

    // Called right after the clock edge that registered a vsync rising edge
    task automatic model_edge();
        int k;
        if (!m_on) return;
        m_edge++;
        if (m_edge <= m_skip) return;
        if (m_edge == m_skip + 1) begin
            push_ev(1'b1, 1'b0, 0, m_err);
            x_en = 1'b1;
            return;
        end
        k = m_edge - m_skip - 2;
        m_err = m_err | m_last_bad;
        x_err = m_err;
        if (m_stop_req || (m_count != 0 && k + 1 == m_count)) begin
            push_ev(1'b0, 1'b1, k % 256, m_err);
            m_on   = 1'b0;
            x_en   = 1'b0;
            x_busy = 1'b0;
            x_done = 1'b1;
            x_idx  = k % 256;
        end else begin
            push_ev(1'b1, 1'b1, (k + 1) % 256, m_err);
            x_idx = (k + 1) % 256;
        end
    endtask

    task automatic do_cmd(bit start, bit stop, int skip, int count);
        bus.cmd_start  = start;
        bus.cmd_stop   = stop;
        bus.cfg_skip   = 8'(skip);
        bus.cfg_count  = 8'(count);
        bus.vid_clk_en = 1'b0;
        @(posedge vid_clk);
        #1;
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        if (stop) begin
            if (m_on) begin
                if (m_edge <= m_skip) begin
                    m_on   = 1'b0;
                    x_busy = 1'b0;
                end else begin
                    m_stop_req = 1'b1;
                end
            end
        end else if (start && !m_on) begin
            m_on       = 1'b1;
            m_edge     = 0;
            m_skip     = skip;
            m_count    = count;
            m_stop_req = 1'b0;
            m_err      = 1'b0;
            x_busy     = 1'b1;
            x_done     = 1'b0;
            x_idx      = 0;
            x_err      = 1'b0;
            x_en       = 1'b0;
        end
    endtask

    // One frame: vsync, blanking, H lines of W pixels (last line short when bad)
    task automatic send_frame(bit bad, bit stop_mid);
        int n;
        int hb;
        ptick(1'b1, 1'b0);
        model_edge();
        m_last_bad = bad;
        for (int i = 0; i < 1 + int'($urandom_range(2)); i++) ptick(1'b1, 1'b0);
        for (int i = 0; i < 2 + int'($urandom_range(2)); i++) ptick(1'b0, 1'b0);
        for (int l = 0; l < int'(H); l++) begin
            n  = (bad && l == int'(H) - 1) ? int'(W) - 1 : int'(W);
            hb = 1 + int'($urandom_range(2));
            for (int p = 0; p < n; p++) ptick(1'b0, 1'b1);
            ptick(1'b0, 1'b0);
            if (stop_mid && l == 1) do_cmd(1'b0, 1'b1, 0, 0);
            for (int i = 0; i < hb; i++) ptick(1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (4) ptick(1'b0, 1'b0);
    endtask

    task automatic run_basic();
        do_cmd(1'b1, 1'b0, 2, 3);
        for (int i = 0; i < 7; i++) send_frame(1'b0, 1'b0);
        settle();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_pos;
        bus.vid_clk_en = 1'b0;
        bus.vid_vsync  = 1'b0;
        bus.vid_active = 1'b0;
        bus.cfg_skip   = '0;
        bus.cfg_count  = '0;
        bus.cmd_start  = 1'b0;
        bus.cmd_stop   = 1'b0;
        m_on = 1'b0; m_stop_req = 1'b0; m_err = 1'b0; m_last_bad = 1'b0;
        m_edge = 0; m_skip = 0; m_count = 0;
        x_en = 1'b0; x_busy = 1'b0; x_done = 1'b0; x_err = 1'b0; x_idx = 0;

        #1 vid_rst = 1'b1;
        repeat (3) @(posedge vid_clk);
        #1 vid_rst = 1'b0;
        drive_tick(1'b1, 1'b0, 1'b0);
        drive_tick(1'b1, 1'b0, 1'b0);

        // Skip 2, capture 3
        run_basic();

        // Short frame sets the sticky error; a new start clears it
        bad_pos = 1 + int'($urandom_range(1));
        do_cmd(1'b1, 1'b0, 0, 4);
        for (int i = 0; i < 6; i++) send_frame(i == bad_pos, 1'b0);
        settle();
        do_cmd(1'b1, 1'b0, 1, 1);
        for (int i = 0; i < 3; i++) send_frame(1'b0, 1'b0);
        settle();

        // Stop while capturing finishes the current frame
        do_cmd(1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 5; i++) send_frame(1'b0, i == 2);
        settle();

        // Stop while skipping returns to idle with no capture
        do_cmd(1'b1, 1'b0, 3, 2);
        send_frame(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_frame(1'b0, 1'b0);
        settle();

        // Start and stop together from idle
        do_cmd(1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 2; i++) send_frame(1'b0, 1'b0);
        settle();

        // Reset in the middle of a captured frame
        do_cmd(1'b1, 1'b0, 0, 0);
        send_frame(1'b0, 1'b0);
        ptick(1'b1, 1'b0);
        model_edge();
        m_last_bad = 1'b0;
        ptick(1'b1, 1'b0);
        ptick(1'b0, 1'b0);
        ptick(1'b0, 1'b1);
        ptick(1'b0, 1'b1);
        #2;
        vid_rst = 1'b1;
        m_on = 1'b0; m_stop_req = 1'b0; m_err = 1'b0;
        x_en = 1'b0; x_busy = 1'b0; x_done = 1'b0; x_err = 1'b0; x_idx = 0;
        @(posedge vid_clk);
        #1;
        @(posedge vid_clk);
        #1;
        vid_rst = 1'b0;
        for (int i = 0; i < 2; i++) send_frame(1'b0, 1'b0);
        settle();

        // Pixel enable at 1-in-3 duty
        dead = 2;
        run_basic();
        dead = 0;

        // Continuous capture across the index wrap, then stop
        do_cmd(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 303; i++) send_frame(1'b0, i == 301);
        settle();

        final_req = 1'b1;
        repeat (3) @(posedge vid_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
